// File: rtl/des_pkg.sv
// Shared widths and block type for the DES block packer and its FIFO.
package des_pkg;
  localparam int DES_BLOCK_W   = 64;
  localparam int PIPE_WORD_W   = 16;
  localparam int WORDS_PER_BLK = 4;
  localparam int WORD_IDX_W    = $clog2(WORDS_PER_BLK);

  typedef logic [DES_BLOCK_W-1:0] des_block_t;

  // Drops one pipe word into its slot of a block; word 0 occupies the low bits.
  function automatic des_block_t place_word(input des_block_t blk,
                                            input logic [WORD_IDX_W-1:0] idx,
                                            input logic [PIPE_WORD_W-1:0] word);
    des_block_t r;
    r = blk;
    r[idx*PIPE_WORD_W +: PIPE_WORD_W] = word;
    return r;
  endfunction
endpackage

// File: rtl/des_block_fifo.sv
// First-fall-through block FIFO; a push while full is accepted only if a pop
// happens on the same edge.
module des_block_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  des_block_t               din,
  input  logic                     pop,
  output des_block_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  des_block_t      mem [DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic            wr_en, rd_en;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/des_block_packer.sv
// Packs 16-bit pipe words into 64-bit DES blocks and queues them for the engine.
// Build option DES_PACKER_PAD_EN: flush zero-fills and pushes a partial block.
module des_block_packer
  import des_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk1,
  input  logic                     reset_n,
  input  logic                     in_write,
  input  logic [PIPE_WORD_W-1:0]   in_data,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     clr_status,
  output logic                     out_valid,
  output logic [DES_BLOCK_W-1:0]   out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         blk_count
);
  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_BLK-1);

  logic [WORD_IDX_W-1:0] idx_q, idx_d;
  des_block_t            asm_q, asm_d, blk;
  logic                  push, full, empty, pop_fire, drop, accept;
  logic                  ovf_q;
  logic [CNT_W-1:0]      cnt_q;

  // Assembly register is cleared at every block boundary so a padded flush
  // naturally sees zeros in the unwritten slots.
  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    push  = 1'b0;
    blk   = asm_q;
    if (in_write) begin
      asm_d = place_word(asm_q, idx_q, in_data);
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        push  = 1'b1;
        blk   = asm_d;
        asm_d = '0;
        idx_d = '0;
      end
    end
    if (flush && idx_d != '0) begin
`ifdef DES_PACKER_PAD_EN
      push = 1'b1;
      blk  = asm_d;
`endif
      asm_d = '0;
      idx_d = '0;
    end
  end

  assign pop_fire = out_ready && !empty;
  assign drop     = push && full && !pop_fire;
  assign accept   = push && !drop;

  des_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk1),
    .rst_n (reset_n),
    .push  (accept),
    .din   (blk),
    .pop   (out_ready),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      asm_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      // A push or drop on the clearing cycle still registers.
      ovf_q <= clr_status ? drop : (ovf_q | drop);
      cnt_q <= (clr_status ? '0 : cnt_q) + CNT_W'(accept);
    end
  end

  assign out_valid = !empty;
  assign in_ready  = !(full && idx_q == LAST_IDX);
  assign overflow  = ovf_q;
  assign blk_count = cnt_q;
endmodule
